subtractor_4bit: RTL and testbench



---
 rtl/subtractor_pkg.sv | 12 +
 rtl/subtractor_4bit_full_subtractor.sv | 13 +
 rtl/subtractor_4bit.sv | 70 +++++++
 tb/tb_subtractor_4bit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pkg.sv
// Shared constants and result type for the registered ripple-borrow subtractor.
package subtractor_pkg;

  localparam int unsigned SUB_DEFAULT_WIDTH = 4;

  // Combinational subtractor result at the default width.
  typedef struct packed {
    logic [SUB_DEFAULT_WIDTH-1:0] diff;
    logic                         borrow;
  } sub_result_t;

endpackage

// File: rtl/subtractor_4bit_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtractor_4bit.sv
// Registered ripple-borrow subtractor, MSB-first operands (index 0 = MSB).
// Optional signed-overflow output enabled by defining SUBTRACTOR_OVF_EN.
module subtractor_4bit
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:WIDTH-1] in1,
  input  logic [0:WIDTH-1] in2,
  input  logic             borrow_in,
  output logic [0:WIDTH-1] out,
  output logic             borrow_out
`ifdef SUBTRACTOR_OVF_EN
  ,
  output logic             overflow
`endif
);

  logic [0:WIDTH-1] w_diff;
  logic [WIDTH:0]   w_borrow;
  logic [0:WIDTH-1] r_out;
  logic             r_borrow;

  assign w_borrow[0] = borrow_in;

  // Cell k handles bit weight 2^k, which sits at vector index WIDTH-1-k.
  for (genvar k = 0; k < WIDTH; k++) begin : g_cell
    full_subtractor u_fs (
      .a    (in1[WIDTH-1-k]),
      .b    (in2[WIDTH-1-k]),
      .bin  (w_borrow[k]),
      .d    (w_diff[WIDTH-1-k]),
      .bout (w_borrow[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out    <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_out    <= w_diff;
      r_borrow <= w_borrow[WIDTH];
    end
  end

  assign out        = r_out;
  assign borrow_out = r_borrow;

`ifdef SUBTRACTOR_OVF_EN
  logic w_ovf;
  logic r_ovf;

  // Signed overflow: operand signs differ and the result sign departs from the minuend.
  assign w_ovf = (in1[0] != in2[0]) && (w_diff[0] != in1[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf;
    end
  end

  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_subtractor_4bit.sv
// Directed and golden-model bench for subtractor_4bit.
module tb_subtractor_4bit;

  logic       clk;
  logic       rst;
  logic [0:3] in1;
  logic [0:3] in2;
  logic       borrow_in;
  logic [0:3] out;
  logic       borrow_out;
`ifdef SUBTRACTOR_OVF_EN
  logic       overflow;
`endif

  int checks;
  int failures;

  subtractor_4bit #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in1        (in1),
    .in2        (in2),
    .borrow_in  (borrow_in),
    .out        (out),
    .borrow_out (borrow_out)
`ifdef SUBTRACTOR_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply operands on the falling edge so they are stable at the next rising edge.
  task automatic drive(input logic [0:3] a, input logic [0:3] b, input logic bi);
    @(negedge clk);
    in1       = a;
    in2       = b;
    borrow_in = bi;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in1       = 4'b1111;
    in2       = 4'b0001;
    borrow_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out !== 4'b0000) begin
        failures++;
        $display("FAIL reset_out cycle=%0d got=%b exp=0000", c, out);
      end
      checks++;
      if (borrow_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_borrow cycle=%0d got=%b exp=0", c, borrow_out);
      end
`ifdef SUBTRACTOR_OVF_EN
      checks++;
      if (overflow !== 1'b0) begin
        failures++;
        $display("FAIL reset_ovf cycle=%0d got=%b exp=0", c, overflow);
      end
`endif
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    drive(4'd9, 4'd3, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out !== 4'b0110) begin
      failures++;
      $display("FAIL basic_out got=%b exp=0110", out);
    end
    checks++;
    if (borrow_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_borrow got=%b exp=0", borrow_out);
    end
  endtask

  task automatic test_borrow();
    drive(4'd3, 4'd9, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out !== 4'b1010) begin
      failures++;
      $display("FAIL borrow_out_val got=%b exp=1010", out);
    end
    checks++;
    if (borrow_out !== 1'b1) begin
      failures++;
      $display("FAIL borrow_flag got=%b exp=1", borrow_out);
    end
  endtask

  task automatic test_equal_wrap();
    drive(4'd5, 4'd5, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (out !== 4'b1111) begin
      failures++;
      $display("FAIL wrap_out got=%b exp=1111", out);
    end
    checks++;
    if (borrow_out !== 1'b1) begin
      failures++;
      $display("FAIL wrap_borrow got=%b exp=1", borrow_out);
    end
    drive(4'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out !== 4'b0000) begin
      failures++;
      $display("FAIL zero_out got=%b exp=0000", out);
    end
    checks++;
    if (borrow_out !== 1'b0) begin
      failures++;
      $display("FAIL zero_borrow got=%b exp=0", borrow_out);
    end
    drive(4'd7, 4'd7, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (borrow_out !== 1'b0 || out !== 4'b0000) begin
      failures++;
      $display("FAIL equal_nobin got=%b/%b exp=0/0000", borrow_out, out);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:3] a;
    logic [0:3] b;
    logic       bi;
    logic [4:0] exp;
`ifdef SUBTRACTOR_OVF_EN
    logic       exp_ovf;
`endif
    for (int n = 0; n < 20; n++) begin
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      bi  = 1'($urandom_range(0, 1));
      exp = {1'b0, a} - {1'b0, b} - 5'(bi);
`ifdef SUBTRACTOR_OVF_EN
      exp_ovf = (a[0] != b[0]) && (exp[3] != a[0]);
`endif
      drive(a, b, bi);
      @(posedge clk); #1;
      checks++;
      if (out !== exp[3:0]) begin
        failures++;
        $display("FAIL b2b_out n=%0d a=%0d b=%0d bi=%0d got=%b exp=%b", n, a, b, bi, out, exp[3:0]);
      end
      checks++;
      if (borrow_out !== exp[4]) begin
        failures++;
        $display("FAIL b2b_borrow n=%0d a=%0d b=%0d bi=%0d got=%b exp=%b", n, a, b, bi, borrow_out, exp[4]);
      end
`ifdef SUBTRACTOR_OVF_EN
      checks++;
      if (overflow !== exp_ovf) begin
        failures++;
        $display("FAIL b2b_ovf n=%0d got=%b exp=%b", n, overflow, exp_ovf);
      end
`endif
    end
    // Mid-stream reset with operands that would otherwise borrow.
    drive(4'd2, 4'd11, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out !== 4'b0000 || borrow_out !== 1'b0) begin
      failures++;
      $display("FAIL midrst got=%b/%b exp=0000/0", out, borrow_out);
    end
    drive(4'd12, 4'd4, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out !== 4'b0111 || borrow_out !== 1'b0) begin
      failures++;
      $display("FAIL post_rst got=%b/%b exp=0111/0", out, borrow_out);
    end
  endtask

`ifdef SUBTRACTOR_OVF_EN
  task automatic test_overflow();
    drive(4'b1000, 4'b0001, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out !== 4'b0111 || overflow !== 1'b1 || borrow_out !== 1'b0) begin
      failures++;
      $display("FAIL ovf_set got=%b/%b/%b exp=0111/1/0", out, overflow, borrow_out);
    end
    drive(4'b0111, 4'b0001, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (out !== 4'b0110 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr got=%b/%b exp=0110/0", out, overflow);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_equal_wrap();
    test_back_to_back();
`ifdef SUBTRACTOR_OVF_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
